locked_reg_bank: RTL and testbench
==================================

// Module: locked_reg_bank
// PURPOSE
//   Parametrised register bank with region-based, sticky write locks (CWE-1262 fix).
//   Registers are split into NUM_REGIONS contiguous, equal-sized regions. Each region has one lock bit.
//   Locked writes are blocked, answered with an error response and counted.
//   Sits between the config-bus bridge and security-critical control registers.
// PARAMETERS
//   DATA_W       32  register and data width
//   DEPTH        8   number of registers; must be a multiple of NUM_REGIONS
//   NUM_REGIONS  2   number of lock regions; region(a) = a / (DEPTH/NUM_REGIONS)
//   ADDR_W       3   address width; must be >= $clog2(DEPTH)
//   CNT_W        8   width of the violation counter
// PORTS
//   clk            in   1                       clock, rising edge
//   rst            in   1                       synchronous, active-high reset
//   wr_valid       in   1                       write request
//   wr_ready       out  1                       bank can accept a write
//   wr_addr        in   ADDR_W                  write address
//   wr_data        in   DATA_W                  write data
//   wr_resp_valid  out  1                       write response strobe
//   wr_resp_code   out  2                       OK / LOCKED / BADADDR
//   rd_en          in   1                       read request
//   rd_addr        in   ADDR_W                  read address
//   rd_data        out  DATA_W                  read data; 0 for an out-of-range address
//   lock_set       in   1                       lock strobe
//   lock_region    in   $clog2(NUM_REGIONS)     region to lock (width 1 if NUM_REGIONS==1)
//   lock_status    out  NUM_REGIONS             current lock bits
//   viol_cnt       out  CNT_W                   saturating count of blocked writes
//   viol_irq       out  1                       one-cycle pulse per blocked write
// BEHAVIOUR
//   Reset values: all registers 0, lock_status 0, viol_cnt 0, rd_data 0, wr_resp_valid 0,
//     wr_resp_code OK, viol_irq 0. wr_ready is 0 while rst is high and 1 otherwise.
//   Write handshake: a write is accepted when wr_valid && wr_ready. The response appears exactly 1 cycle later:
//     wr_resp_valid=1 for one cycle, with wr_resp_code set. One write per cycle; back-to-back writes are allowed.
//   Write decision, made in the accept cycle:
//     - wr_addr >= DEPTH: BADADDR. No write. Not a violation.
//     - effective lock of region(wr_addr) set: LOCKED. No write. viol_irq pulses on the response cycle.
//       viol_cnt += 1, saturating at 2^CNT_W-1.
//     - otherwise: OK. The register takes wr_data at this clock edge.
//   Effective lock = lock_status[r] | (lock_set && lock_region==r). A write in the same cycle as the lock of
//     its region is therefore blocked; there is no window where a lock is pending but not enforced.
//   Locks are sticky: once set, cleared only by rst. lock_set on an already locked region has no effect.
//     lock_set with lock_region >= NUM_REGIONS is ignored.
//   Read: rd_data registered, 1-cycle latency. It updates only when rd_en=1 and otherwise holds its value.
//     A read in the same cycle as a write to the same address returns the pre-write value.
//     Reads are never lock-gated.
//   Reset in mid-operation: rst overrides everything in that cycle. Pending responses are dropped
//     (wr_resp_valid=0 on the next cycle). Locks and counters are cleared.
//   Lock mapping is uniform. Every register in a region uses the same lock bit, and no register is unlocked
//     by construction.
// STRUCTURE
//   locked_reg_bank_pkg:
//     - resp_e enum: RESP_OK=2'd0, RESP_LOCKED=2'd1, RESP_BADADDR=2'd2
//     - function region_of(addr) for the region mapping
//   Sub-module reg_lock_ctrl: holds the sticky lock bits, the effective-lock compare, the saturating
//     violation counter and the irq pulse.
//   Top level: register array, address decode, response pipeline register, read register.
//   Elaboration checks: DEPTH % NUM_REGIONS == 0; 2^ADDR_W >= DEPTH.
// TESTING (defaults DEPTH=8, NUM_REGIONS=2)
//   1. Write 0xA5A5_0001 to addr 2, no locks -> next cycle resp OK; reading addr 2 returns 0xA5A5_0001.
//   2. lock region 0; write 0xDEAD_BEEF to addr 1 -> resp LOCKED, viol_irq pulse, viol_cnt=1, addr 1 unchanged;
//      write to addr 5 -> OK.
//   3. Same cycle: lock_set region 1 and write to addr 6 -> resp LOCKED, addr 6 unchanged; lock_status=2'b10.
//   4. Write to addr 8 (ADDR_W=4 variant) -> resp BADADDR, viol_cnt unchanged; reading addr 8 returns 0.
//   5. CNT_W=2, 5 blocked writes -> viol_cnt saturates at 3, viol_irq pulses 5 times.
//   6. Assert rst the cycle after a write is accepted -> no resp_valid; locks=0, regs=0, wr_ready=0 during rst.

Source files
------------

// File: rtl/locked_reg_bank_pkg.sv
// Shared types and helpers for the lock-protected register bank.
package locked_reg_bank_pkg;

    typedef enum logic [1:0] {
        RESP_OK      = 2'd0,
        RESP_LOCKED  = 2'd1,
        RESP_BADADDR = 2'd2
    } resp_e;

    // Regions are contiguous and equal-sized, so the mapping is a plain division.
    function automatic int unsigned region_of(input int unsigned addr,
                                              input int unsigned depth,
                                              input int unsigned num_regions);
        return addr / (depth / num_regions);
    endfunction

endpackage

// File: rtl/locked_reg_bank_lock_ctrl.sv
// Sticky per-region lock bits, effective-lock check for the incoming write,
// saturating violation counter and one-cycle violation pulse.
module reg_lock_ctrl #(
    parameter int unsigned NUM_REGIONS = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned RGN_W       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lock_set,
    input  logic [RGN_W-1:0]       lock_region,
    input  logic                   chk_valid,
    input  logic [RGN_W-1:0]       chk_region,
    output logic                   chk_locked,
    output logic [NUM_REGIONS-1:0] lock_status,
    output logic [CNT_W-1:0]       viol_cnt,
    output logic                   viol_irq
);

    logic [NUM_REGIONS-1:0] lock_status_d, lock_status_q;
    logic [CNT_W-1:0]       viol_cnt_d, viol_cnt_q;
    logic                   viol_irq_d, viol_irq_q;
    logic                   viol;

    always_comb begin
        lock_status_d = lock_status_q;
        chk_locked    = 1'b0;
        for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
            if (lock_set && (32'(lock_region) == r)) begin
                lock_status_d[r] = 1'b1;
            end
            // Checking the post-set bit makes a same-cycle lock block the write.
            if (32'(chk_region) == r) begin
                chk_locked = lock_status_d[r];
            end
        end
        viol       = chk_valid && chk_locked;
        viol_irq_d = viol;
        viol_cnt_d = viol_cnt_q;
        if (viol && (viol_cnt_q != '1)) begin
            viol_cnt_d = viol_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_status_q <= '0;
            viol_cnt_q    <= '0;
            viol_irq_q    <= 1'b0;
        end else begin
            lock_status_q <= lock_status_d;
            viol_cnt_q    <= viol_cnt_d;
            viol_irq_q    <= viol_irq_d;
        end
    end

    assign lock_status = lock_status_q;
    assign viol_cnt    = viol_cnt_q;
    assign viol_irq    = viol_irq_q;

endmodule

// File: rtl/locked_reg_bank.sv
// Register bank with region-based sticky write locks; blocked writes are
// answered LOCKED, counted and signalled on viol_irq.
module locked_reg_bank
    import locked_reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned NUM_REGIONS = 2,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_resp_valid,
    output logic [1:0]             wr_resp_code,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [DATA_W-1:0]      rd_data,
    input  logic                   lock_set,
    input  logic [((NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1)-1:0] lock_region,
    output logic [NUM_REGIONS-1:0] lock_status,
    output logic [CNT_W-1:0]       viol_cnt,
    output logic                   viol_irq
);

    localparam int unsigned RGN_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH % NUM_REGIONS != 0) begin : g_bad_regions
        $error("DEPTH must be a multiple of NUM_REGIONS");
    end
    if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
        $error("ADDR_W too narrow for DEPTH");
    end

    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              resp_valid_d, resp_valid_q;
    resp_e             resp_code_d, resp_code_q;
    logic [DATA_W-1:0] rd_data_d, rd_data_q;

    logic              wr_accept, wr_in_range, rd_in_range, wr_locked;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [RGN_W-1:0]  wr_region;

    assign wr_ready    = !rst;
    assign wr_accept   = wr_valid && wr_ready;
    assign wr_in_range = 32'(wr_addr) < DEPTH;
    assign rd_in_range = 32'(rd_addr) < DEPTH;
    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = rd_addr[IDX_W-1:0];
    assign wr_region   = RGN_W'(region_of(32'(wr_addr), DEPTH, NUM_REGIONS));

    reg_lock_ctrl #(
        .NUM_REGIONS (NUM_REGIONS),
        .CNT_W       (CNT_W),
        .RGN_W       (RGN_W)
    ) u_lock_ctrl (
        .clk         (clk),
        .rst         (rst),
        .lock_set    (lock_set),
        .lock_region (lock_region),
        .chk_valid   (wr_accept && wr_in_range),
        .chk_region  (wr_region),
        .chk_locked  (wr_locked),
        .lock_status (lock_status),
        .viol_cnt    (viol_cnt),
        .viol_irq    (viol_irq)
    );

    always_comb begin
        regs_d       = regs_q;
        resp_valid_d = wr_accept;
        resp_code_d  = resp_code_q;
        if (wr_accept) begin
            if (!wr_in_range) begin
                resp_code_d = RESP_BADADDR;
            end else if (wr_locked) begin
                resp_code_d = RESP_LOCKED;
            end else begin
                resp_code_d    = RESP_OK;
                regs_d[wr_idx] = wr_data;
            end
        end
        // Reads sample regs_q, so a colliding write is not yet visible.
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_in_range ? regs_q[rd_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q       <= '{default: '0};
            resp_valid_q <= 1'b0;
            resp_code_q  <= RESP_OK;
            rd_data_q    <= '0;
        end else begin
            regs_q       <= regs_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign wr_resp_valid = resp_valid_q;
    assign wr_resp_code  = resp_code_q;
    assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_locked_reg_bank.sv
// Directed and random checks of locked_reg_bank against a behavioural model.
module tb_locked_reg_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic        lock_set = 1'b0;
    logic [0:0]  lock_region = '0;

    logic        wr_ready, wr_resp_valid, viol_irq;
    logic [1:0]  wr_resp_code, lock_status;
    logic [31:0] rd_data;
    logic [7:0]  viol_cnt;

    logic        s_wr_ready, s_wr_resp_valid, s_viol_irq;
    logic [1:0]  s_wr_resp_code, s_lock_status, s_viol_cnt;
    logic [31:0] s_rd_data;

    always #5 clk = ~clk;

    locked_reg_bank #(
        .DATA_W (32), .DEPTH (8), .NUM_REGIONS (2), .ADDR_W (4), .CNT_W (8)
    ) dut (
        .clk (clk), .rst (rst), .wr_valid (wr_valid), .wr_ready (wr_ready),
        .wr_addr (wr_addr), .wr_data (wr_data), .wr_resp_valid (wr_resp_valid),
        .wr_resp_code (wr_resp_code), .rd_en (rd_en), .rd_addr (rd_addr),
        .rd_data (rd_data), .lock_set (lock_set), .lock_region (lock_region),
        .lock_status (lock_status), .viol_cnt (viol_cnt), .viol_irq (viol_irq)
    );

    // Narrow-counter instance sharing all inputs, for saturation behaviour.
    locked_reg_bank #(
        .DATA_W (32), .DEPTH (8), .NUM_REGIONS (2), .ADDR_W (4), .CNT_W (2)
    ) dut_s (
        .clk (clk), .rst (rst), .wr_valid (wr_valid), .wr_ready (s_wr_ready),
        .wr_addr (wr_addr), .wr_data (wr_data), .wr_resp_valid (s_wr_resp_valid),
        .wr_resp_code (s_wr_resp_code), .rd_en (rd_en), .rd_addr (rd_addr),
        .rd_data (s_rd_data), .lock_set (lock_set), .lock_region (lock_region),
        .lock_status (s_lock_status), .viol_cnt (s_viol_cnt), .viol_irq (s_viol_irq)
    );

    int n_cmp = 0;
    int n_err = 0;
    int s_pulses = 0;

    logic [31:0] mem [8];
    bit   [1:0]  locks;
    int          viols;
    bit          e_valid, e_irq, e_code_chk;
    logic [1:0]  e_code;
    logic [31:0] e_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic cycle(input bit r, input bit wv, input logic [3:0] wa,
                         input logic [31:0] wd, input bit re, input logic [3:0] ra,
                         input bit ls, input bit lr);
        int reg_of_wa;
        @(negedge clk);
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; lock_set = ls; lock_region = lr;
        #1;
        chk("wr_ready", {63'd0, wr_ready}, {63'd0, !r});
        chk("s_wr_ready", {63'd0, s_wr_ready}, {63'd0, !r});
        if (r) begin
            foreach (mem[i]) mem[i] = '0;
            locks = '0; viols = 0;
            e_valid = 0; e_irq = 0; e_code = 2'd0; e_code_chk = 1; e_rd = '0;
        end else begin
            if (re) e_rd = (ra < 8) ? mem[ra[2:0]] : 32'd0;
            e_valid = wv; e_irq = 0; e_code_chk = wv;
            if (wv) begin
                reg_of_wa = int'(wa) / 4;
                if (wa >= 8) begin
                    e_code = 2'd2;
                end else if (locks[reg_of_wa] || (ls && int'(lr) == reg_of_wa)) begin
                    e_code = 2'd1; e_irq = 1; viols++;
                end else begin
                    e_code = 2'd0; mem[wa[2:0]] = wd;
                end
            end
            if (ls) locks[lr] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (s_viol_irq === 1'b1) s_pulses++;
        chk("resp_valid", {63'd0, wr_resp_valid}, {63'd0, e_valid});
        if (e_code_chk) chk("resp_code", {62'd0, wr_resp_code}, {62'd0, e_code});
        chk("viol_irq", {63'd0, viol_irq}, {63'd0, e_irq});
        chk("viol_cnt", {56'd0, viol_cnt}, 64'(sat(viols, 255)));
        chk("lock_status", {62'd0, lock_status}, {62'd0, locks});
        chk("rd_data", {32'd0, rd_data}, {32'd0, e_rd});
        chk("s_viol_cnt", {62'd0, s_viol_cnt}, 64'(sat(viols, 3)));
        chk("s_viol_irq", {63'd0, s_viol_irq}, {63'd0, e_irq});
        chk("s_lock_status", {62'd0, s_lock_status}, {62'd0, locks});
    endtask

    initial begin
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_resp_code", {62'd0, wr_resp_code}, 64'd0);

        // Plain write then read back.
        cycle(0, 1, 4'd2, 32'hA5A5_0001, 0, 0, 0, 0);
        chk("t1_resp", {62'd0, wr_resp_code}, 64'd0);
        cycle(0, 0, 0, 0, 1, 4'd2, 0, 0);
        chk("t1_rd", {32'd0, rd_data}, 64'hA5A5_0001);

        // Region 0 locked: writes there blocked, region 1 still open.
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 4'd1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        chk("t2_resp", {62'd0, wr_resp_code}, 64'd1);
        chk("t2_cnt", {56'd0, viol_cnt}, 64'd1);
        cycle(0, 0, 0, 0, 1, 4'd1, 0, 0);
        chk("t2_rd", {32'd0, rd_data}, 64'd0);
        cycle(0, 1, 4'd5, 32'h1234_5678, 0, 0, 0, 0);
        chk("t2_open", {62'd0, wr_resp_code}, 64'd0);

        // Same-cycle lock and write to that region.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 4'd6, 32'h0BAD_F00D, 0, 0, 1, 1);
        chk("t3_resp", {62'd0, wr_resp_code}, 64'd1);
        chk("t3_locks", {62'd0, lock_status}, 64'd2);
        cycle(0, 0, 0, 0, 1, 4'd6, 0, 0);
        chk("t3_rd", {32'd0, rd_data}, 64'd0);

        // Out-of-range address.
        cycle(0, 1, 4'd8, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("t4_resp", {62'd0, wr_resp_code}, 64'd2);
        chk("t4_cnt", {56'd0, viol_cnt}, 64'd1);
        cycle(0, 0, 0, 0, 1, 4'd8, 0, 0);
        chk("t4_rd", {32'd0, rd_data}, 64'd0);

        // Saturation of the 2-bit counter.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        s_pulses = 0;
        for (int i = 0; i < 5; i++) cycle(0, 1, 4'(i), 32'(i), 0, 0, 0, 0);
        chk("t5_sat", {62'd0, s_viol_cnt}, 64'd3);
        chk("t5_pulses", 64'(s_pulses), 64'd5);
        chk("t5_wide", {56'd0, viol_cnt}, 64'd5);

        // Reset right after an accepted write.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 4'd3, 32'hCAFE_0003, 0, 0, 1, 1);
        cycle(1, 1, 4'd4, 32'hCAFE_0004, 0, 0, 0, 0);
        chk("t6_valid", {63'd0, wr_resp_valid}, 64'd0);
        chk("t6_locks", {62'd0, lock_status}, 64'd0);
        cycle(0, 0, 0, 0, 1, 4'd3, 0, 0);
        chk("t6_rd", {32'd0, rd_data}, 64'd0);

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
                  4'($urandom_range(0, 15)), $urandom(),
                  ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
